// File: rtl/lane_deser_pkg.sv
// lane_deser_pkg: shared FSM state enum and default training word / lock count
package lane_deser_pkg;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  localparam logic [7:0] TRAIN_DEF = 8'hD3;
  localparam int LOCK_CNT_DEF = 4;
endpackage

// File: rtl/lane_deserializer_if.sv
// lane_deserializer_if: lane bus; master drives din/relock, slave returns dout/dout_valid/idx/locked/slip
interface lane_deserializer_if #(parameter int K = 3);
  logic din;
  logic relock;
  logic [2**K-1:0] dout;
  logic dout_valid;
  logic [K-1:0] idx;
  logic locked;
  logic slip;
  modport master (output din, relock, input dout, dout_valid, idx, locked, slip);
  modport slave (input din, relock, output dout, dout_valid, idx, locked, slip);
endinterface

// File: rtl/lane_deser_capture.sv
// lane_deser_capture: bit capture; in clk, rst (async low), din, slip_req; out idx, slip, done, word
module lane_deser_capture #(
  parameter int K = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            slip_req,
  output logic [K-1:0]    idx,
  output logic            slip,
  output logic            done,
  output logic [2**K-1:0] word
);
  localparam int M = 2**K;
  logic [M-1:0] sh;
  assign done = &idx && !slip;
  always_comb begin
    word = sh;
    word[M-1] = din;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      sh <= '0;
      slip <= 1'b0;
    end else begin
      slip <= slip_req;
      if (!slip) begin
        sh[idx] <= din;
        idx <= idx + 1'b1;
      end
    end
endmodule

// File: rtl/lane_deserializer.sv
// lane_deserializer: serial-to-word deserializer with TRAIN-word alignment; ports clk, rst (async low), bus (slave)
module lane_deserializer import lane_deser_pkg::*; #(
  parameter int K = 3,
  parameter logic [2**K-1:0] TRAIN = TRAIN_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input logic clk,
  input logic rst,
  lane_deserializer_if.slave bus
);
  localparam int M = 2**K;
  localparam int CW = $clog2(LOCK_CNT + 1);
  state_t state, state_n;
  logic [CW-1:0] match_cnt, match_cnt_n;
  logic slip_req, done, hit, deliver;
  logic [M-1:0] word;
  lane_deser_capture #(.K(K)) u_cap (
    .clk(clk),
    .rst(rst),
    .din(bus.din),
    .slip_req(slip_req),
    .idx(bus.idx),
    .slip(bus.slip),
    .done(done),
    .word(word)
  );
  assign hit = word == TRAIN;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= SEARCH;
      match_cnt <= '0;
    end else begin
      state <= state_n;
      match_cnt <= match_cnt_n;
    end
  always_comb begin
    state_n = state;
    match_cnt_n = match_cnt;
    slip_req = 1'b0;
    if (bus.relock) begin
      state_n = SEARCH;
      match_cnt_n = '0;
    end else if (done)
      case (state)
        SEARCH:
          if (hit) begin
            state_n = LOCK_CNT == 1 ? LOCKED : CHECK;
            match_cnt_n = CW'(1);
          end else
            slip_req = 1'b1;
        CHECK:
          if (hit) begin
            match_cnt_n = match_cnt + 1'b1;
            state_n = match_cnt_n == CW'(LOCK_CNT) ? LOCKED : CHECK;
          end else begin
            state_n = SEARCH;
            match_cnt_n = '0;
            slip_req = 1'b1;
          end
        default: ;
      endcase
  end
  // A word completing together with relock is dropped, never delivered
  always_comb begin
    bus.locked = state == LOCKED;
    deliver = done && !bus.relock && state == LOCKED;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.dout <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= deliver;
      if (deliver) bus.dout <= word;
    end
endmodule

// File: tb/tb_lane_deserializer.sv
// tb_lane_deserializer: scoreboard bench for lane_deserializer (K=3, TRAIN=D3, LOCK_CNT=4)
module tb_lane_deserializer;
  import lane_deser_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int slips = 0;
  int valids = 0;
  logic [7:0] q[$];
  logic [7:0] sb_exp;
  logic [7:0] t = 8'hD3;
  lane_deserializer_if #(.K(3)) bus();
  lane_deserializer #(.K(3), .TRAIN(8'hD3), .LOCK_CNT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.slip) slips++;
    if (bus.dout_valid) begin
      valids++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra got dout=%h expected no valid", bus.dout);
      end else begin
        sb_exp = q.pop_front();
        if (bus.dout !== sb_exp) begin
          failures++;
          $display("FAIL sb_dout got=%h exp=%h", bus.dout, sb_exp);
        end
      end
    end
  end
  task automatic send_bit(input logic b);
    bus.din = b;
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask
  task automatic do_reset();
    bus.din = 1'b0;
    bus.relock = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  task automatic test_reset();
    bus.din = 1'b0;
    bus.relock = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) send_bit(1'b1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.idx, bus.dout, bus.dout_valid, bus.slip, bus.locked} !== 14'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", {bus.idx, bus.dout, bus.dout_valid, bus.slip, bus.locked});
    end
    checks++;
    if (dut.u_cap.sh !== 8'h00) begin
      failures++;
      $display("FAIL reset_partial_word got=%h exp=00", dut.u_cap.sh);
    end
    for (int i = 0; i < 6; i++) begin
      bus.din = i[0];
      @(posedge clk);
      #1;
      checks++;
      if ({bus.idx, bus.dout, bus.dout_valid, bus.slip, bus.locked} !== 14'h0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, {bus.idx, bus.dout, bus.dout_valid, bus.slip, bus.locked});
      end
    end
    rst = 1'b1;
    checks++;
    if (bus.idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_release_idx got=%0d exp=0", bus.idx);
    end
    send_bit(1'b1);
    checks++;
    if (bus.idx !== 3'd1) begin
      failures++;
      $display("FAIL reset_first_capture got=%0d exp=1", bus.idx);
    end
  endtask
  task automatic test_aligned();
    do_reset();
    slips = 0;
    valids = 0;
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bus.idx !== 3'(i)) begin
          failures++;
          $display("FAIL aligned_idx w=%0d got=%0d exp=%0d", w, bus.idx, i);
        end
        send_bit(t[i]);
        if (!(w == 3 && i == 7)) begin
          checks++;
          if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL aligned_early_lock w=%0d b=%0d got=1 exp=0", w, i);
          end
        end
      end
    checks++;
    if (bus.locked !== 1'b1) begin
      failures++;
      $display("FAIL aligned_lock got=%b exp=1", bus.locked);
    end
    checks++;
    if (slips != 0 || valids != 0) begin
      failures++;
      $display("FAIL aligned_pulses got slips=%0d valids=%0d exp 0/0", slips, valids);
    end
  endtask
  task automatic test_data();
    logic [7:0] d = 8'h5A;
    logic [7:0] r;
    q.push_back(d);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL data_early_valid got=1 exp=0");
    end
    send_bit(d[7]);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h5A) begin
      failures++;
      $display("FAIL data_latency got valid=%b dout=%h exp 1/5a", bus.dout_valid, bus.dout);
    end
    send_bit(1'b1);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h5A) begin
      failures++;
      $display("FAIL data_hold got valid=%b dout=%h exp 0/5a", bus.dout_valid, bus.dout);
    end
    for (int i = 1; i < 8; i++) send_bit(1'b0);
    q.push_back(8'h01);
    for (int n = 0; n < 3; n++) begin
      r = 8'($urandom);
      q.push_back(r);
      send_word(r);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL data_sb_drain got=%0d exp=0", q.size());
    end
  endtask
  task automatic test_offset();
    logic b;
    do_reset();
    slips = 0;
    valids = 0;
    for (int n = 0; n < 59; n++) begin
      b = n < 3 ? 1'b0 : t[(n - 3) % 8];
      send_bit(b);
      if (n == 57) begin
        checks++;
        if (bus.locked !== 1'b0) begin
          failures++;
          $display("FAIL offset_early_lock got=1 exp=0");
        end
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      failures++;
      $display("FAIL offset_lock got=%b exp=1", bus.locked);
    end
    checks++;
    if (slips != 3 || valids != 0) begin
      failures++;
      $display("FAIL offset_slips got slips=%0d valids=%0d exp 3/0", slips, valids);
    end
  endtask
  task automatic test_check_fail();
    do_reset();
    slips = 0;
    send_word(8'hD3);
    send_word(8'hD3);
    checks++;
    if (dut.state !== CHECK || dut.match_cnt !== 3'd2) begin
      failures++;
      $display("FAIL chk_pre got state=%0d cnt=%0d exp CHECK/2", dut.state, dut.match_cnt);
    end
    send_word(8'h00);
    checks++;
    if (dut.state !== SEARCH || dut.match_cnt !== 3'd0) begin
      failures++;
      $display("FAIL chk_fail_state got state=%0d cnt=%0d exp SEARCH/0", dut.state, dut.match_cnt);
    end
    checks++;
    if (bus.slip !== 1'b1 || bus.idx !== 3'd0 || bus.locked !== 1'b0) begin
      failures++;
      $display("FAIL chk_slip got slip=%b idx=%0d locked=%b exp 1/0/0", bus.slip, bus.idx, bus.locked);
    end
    send_bit(1'b1);
    checks++;
    if (bus.slip !== 1'b0 || bus.idx !== 3'd0) begin
      failures++;
      $display("FAIL chk_after_slip got slip=%b idx=%0d exp 0/0", bus.slip, bus.idx);
    end
    send_bit(1'b1);
    checks++;
    if (bus.idx !== 3'd1 || slips != 1) begin
      failures++;
      $display("FAIL chk_resume got idx=%0d slips=%0d exp 1/1", bus.idx, slips);
    end
  endtask
  task automatic test_relock();
    logic [7:0] f = 8'hFF;
    do_reset();
    slips = 0;
    repeat (4) send_word(8'hD3);
    q.push_back(8'h5A);
    send_word(8'h5A);
    for (int i = 0; i < 7; i++) send_bit(f[i]);
    bus.relock = 1'b1;
    send_bit(f[7]);
    bus.relock = 1'b0;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h5A) begin
      failures++;
      $display("FAIL relock_drop got valid=%b dout=%h exp 0/5a", bus.dout_valid, bus.dout);
    end
    checks++;
    if (bus.locked !== 1'b0 || bus.slip !== 1'b0 || bus.idx !== 3'd0) begin
      failures++;
      $display("FAIL relock_state got locked=%b slip=%b idx=%0d exp 0/0/0", bus.locked, bus.slip, bus.idx);
    end
    send_bit(1'b0);
    checks++;
    if (bus.idx !== 3'd1 || dut.state !== SEARCH || slips != 0) begin
      failures++;
      $display("FAIL relock_resume got idx=%0d state=%0d slips=%0d exp 1/SEARCH/0", bus.idx, dut.state, slips);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL relock_sb_drain got=%0d exp=0", q.size());
    end
  endtask
  initial begin
    bus.din = 1'b0;
    bus.relock = 1'b0;
    test_reset();
    test_aligned();
    test_data();
    test_offset();
    test_check_fail();
    test_relock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_deserializer.md
LANE_DESERIALIZER -- requirements
Module: lane_deserializer

Interface
REQ-001 K SHALL be a parameter, default 3: log2 of the word width.
REQ-002 M SHALL be a derived localparam equal to 2**K: word width in bits.
REQ-003 TRAIN SHALL be a parameter [M-1:0], default 8'hD3: the alignment training word.
REQ-004 LOCK_CNT SHALL be a parameter, default 4: the number of consecutive TRAIN matches required for lock.
REQ-005 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 din  input  1  SHALL be the serial bit stream, LSB of each word first.
REQ-008 relock  input  1  SHALL be a single-cycle pulse that forces realignment.
REQ-009 dout  output  M  SHALL be the last deserialized word.
REQ-010 dout_valid  output  1  SHALL be a one-cycle pulse marking a new dout word.
REQ-011 idx  output  K  SHALL be the bit position at which din is captured this cycle.
REQ-012 locked  output  1  SHALL be high while the block is in state LOCKED.
REQ-013 slip  output  1  SHALL be a one-cycle pulse marking a discarded (slip) bit cycle.

Function
REQ-014 Capture: each non-slip cycle, din SHALL be written to shift-word bit idx, and idx SHALL increment mod M.
REQ-015 Word completion: a word SHALL complete in a cycle where idx==M-1 and no slip is active.
REQ-016 dout SHALL be registered from the completed word one cycle after completion.
REQ-017 dout_valid SHALL pulse in that same cycle only if the state at completion was LOCKED; latency from last bit SHALL be 1 cycle.
REQ-018 dout SHALL hold its value between valid pulses.
REQ-019 FSM states SHALL be SEARCH, CHECK and LOCKED.
REQ-020 SEARCH, completed word == TRAIN: next state SHALL be CHECK and match_cnt SHALL be set to 1 (if LOCK_CNT==1, next state SHALL be LOCKED instead).
REQ-021 SEARCH, completed word != TRAIN: the block SHALL stay in SEARCH and schedule a slip.
REQ-022 CHECK, match: match_cnt SHALL increment, and the block SHALL go to LOCKED when match_cnt reaches LOCK_CNT.
REQ-023 CHECK, mismatch: the block SHALL go to SEARCH, clear match_cnt and schedule a slip.
REQ-024 LOCKED SHALL persist regardless of data content; it is left only via relock or reset.
REQ-025 Slip: in the cycle after a scheduled slip, din SHALL be discarded, idx SHALL stay 0, and slip SHALL be 1; capture SHALL resume at idx 0 the following cycle, moving the word boundary one bit later.
REQ-026 Each slip SHALL advance the boundary by 1 bit, so any offset d SHALL be aligned after exactly d slips (d < M).
REQ-027 The LOCK_CNT-th matching word SHALL NOT produce dout_valid; locked SHALL rise the cycle after that word completes.
REQ-028 relock SHALL be honoured in any state: next state SEARCH, match_cnt cleared, locked low next cycle, idx continuing unmodified, no slip.
REQ-029 relock coinciding with word completion SHALL take priority: the word is neither evaluated nor delivered, and dout_valid stays 0.
REQ-030 match_cnt SHALL be sized to hold LOCK_CNT and SHALL never wrap.

Reset
REQ-031 While rst is low the block SHALL hold: idx=0, shift word=0, dout=0, dout_valid=0, slip=0, locked=0, match_cnt=0, state=SEARCH.
REQ-032 Reset assertion mid-word SHALL discard the partial word immediately, with no pulse on any output.
REQ-033 After rst rises, the first capture SHALL occur at idx 0 on the first rising clk edge.

Structure
REQ-034 A shared package lane_deser_pkg SHALL hold the FSM state enum and the default TRAIN/LOCK_CNT constants.
REQ-035 One sub-module, lane_deser_capture, SHALL contain the idx counter, shift word and slip hold; the FSM and output registers SHALL stay in the top module.

Verification (K=3, TRAIN=8'hD3, LOCK_CNT=4)
REQ-036 Reset: hold rst low with din toggling -> all outputs 0 throughout; idx=0 first cycle after release.
REQ-037 Aligned: stream 8'hD3 repeatedly LSB-first from idx 0 -> locked rises 1 cycle after word 4; no dout_valid before lock; slip never pulses.
REQ-038 3-bit offset: 3 zero bits, then repeated 8'hD3 -> exactly 3 slip pulses, locked rises 1 cycle after the 4th matched word.
REQ-039 Data after lock: send 8'h5A -> dout=8'h5A with dout_valid high exactly 1 cycle after its 8th bit.
REQ-040 CHECK failure: 2 x 8'hD3, then 8'h00 -> state SEARCH, match_cnt=0, one slip pulse the next cycle, locked stays 0.
REQ-041 relock coincident with completion of word 8'hFF in LOCKED -> no dout_valid, dout unchanged, locked low the next cycle.
